// File: rtl/fifo_drain_fsm_if.sv
// Read-port and status bundle between the FIFO drain controller and its environment.
// master: the drain controller; slave: FIFO/consumer side.
interface fifo_drain_fsm_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
);
  logic              enable;
  logic              clr_stats;
  logic [CNT_W-1:0]  fifo_words;
  logic [DATA_W-1:0] fifo_data;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [15:0]       words_read;
  logic [7:0]        err_count;
  logic              mismatch;

  modport master (
    input  enable, clr_stats, fifo_words, fifo_data,
    output rd_en, data_out, data_valid, words_read, err_count, mismatch
  );

  modport slave (
    output enable, clr_stats, fifo_words, fifo_data,
    input  rd_en, data_out, data_valid, words_read, err_count, mismatch
  );
endinterface

// File: rtl/fifo_drain_fsm.sv
// FIFO read-side controller: drains with high/low watermark hysteresis, captures
// each word, checks it against a fixed pattern and keeps read/error statistics.
module fifo_drain_fsm #(
  parameter int                DATA_W    = 8,
  parameter int                CNT_W     = 4,
  parameter int                HIGH_MARK = 5,
  parameter int                LOW_MARK  = 2,
  parameter logic [DATA_W-1:0] EXPECTED  = 8'hAA
) (
  input logic               clk,
  input logic               rst_n,
  fifo_drain_fsm_if.master  bus
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_C = CNT_W'(HIGH_MARK);
  localparam logic [CNT_W-1:0] LOW_C  = CNT_W'(LOW_MARK);

  state_t            state_r;
  logic              rd_en_s;
  logic              bad_s;
  logic              rd_q_r;
  logic [DATA_W-1:0] data_out_r;
  logic              data_valid_r;
  logic [15:0]       words_read_r;
  logic [7:0]        err_count_r;
  logic              mismatch_r;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

  // Read strobe: never issued at or below the low mark, so an empty FIFO is never popped
  always_comb begin
    rd_en_s = 1'b0;
    bad_s   = 1'b0;
    if ((state_r == ST_READ) && bus.enable && (bus.fifo_words > LOW_C)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
    if (rd_q_r && (bus.fifo_data != EXPECTED)) begin
      bad_s = 1'b1;
    end else begin
      bad_s = 1'b0;
    end
  end

  // Drain state machine: enter READ at the high mark, leave at the low mark
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RESET;
    end else begin
      case (state_r)
        ST_RESET: state_r <= ST_WAIT;
        ST_WAIT:  state_r <= (bus.fifo_words >= HIGH_C) ? ST_READ : ST_WAIT;
        ST_READ:  state_r <= (bus.fifo_words <= LOW_C) ? ST_WAIT : ST_READ;
        default:  state_r <= ST_RESET;
      endcase
    end
  end

  // Capture path: read data arrives the cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q_r       <= 1'b0;
      data_out_r   <= '0;
      data_valid_r <= 1'b0;
    end else begin
      rd_q_r       <= rd_en_s;
      data_valid_r <= rd_q_r;
      if (rd_q_r) begin
        data_out_r <= bus.fifo_data;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  // Statistics; clear has priority over any same-cycle update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_read_r <= 16'd0;
      err_count_r  <= 8'd0;
      mismatch_r   <= 1'b0;
    end else if (bus.clr_stats) begin
      words_read_r <= 16'd0;
      err_count_r  <= 8'd0;
      mismatch_r   <= 1'b0;
    end else begin
      if (rd_en_s) begin
        words_read_r <= words_read_r + 16'd1;
      end else begin
        words_read_r <= words_read_r;
      end
      if (bad_s) begin
        err_count_r <= sat_inc8(err_count_r);
        mismatch_r  <= 1'b1;
      end else begin
        err_count_r <= err_count_r;
        mismatch_r  <= mismatch_r;
      end
    end
  end

  assign bus.rd_en      = rd_en_s;
  assign bus.data_out   = data_out_r;
  assign bus.data_valid = data_valid_r;
  assign bus.words_read = words_read_r;
  assign bus.err_count  = err_count_r;
  assign bus.mismatch   = mismatch_r;

endmodule

// File: tb/tb_fifo_drain_fsm.sv
// Scoreboard bench for fifo_drain_fsm: a FIFO model feeds the DUT and queues the
// expected words; a monitor pops them on every data_valid pulse.
module tb_fifo_drain_fsm;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_drain_fsm_if #(.DATA_W(8), .CNT_W(4)) bus ();

  fifo_drain_fsm #(
    .DATA_W(8), .CNT_W(4), .HIGH_MARK(5), .LOW_MARK(2), .EXPECTED(8'hAA)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         errors = 0;
  int         checks = 0;
  int         dv_cnt = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  bit         stream = 1'b0;
  bit         pend;
  logic [7:0] pop_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] occ();
    return (fifo_q.size() > 15) ? 4'd15 : 4'(fifo_q.size());
  endfunction

  // FIFO model: a strobe seen at negedge pops one word just after the next rising edge
  always begin
    @(negedge clk);
    pend = (rst_n === 1'b1) && (bus.rd_en === 1'b1);
    @(posedge clk);
    #1;
    if (pend && rst_n) begin
      if (fifo_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_on_empty: got rd_en=1 expected rd_en=0");
      end else begin
        pop_d = fifo_q.pop_front();
        bus.fifo_data = pop_d;
        exp_q.push_back(pop_d);
        if (stream) fifo_q.push_back(8'h55);
      end
    end
    bus.fifo_words = occ();
  end

  // Monitor: every data_valid pulse must match the oldest expected word
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.data_valid === 1'b1) begin
      dv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got data_valid=1 data_out=0x%0h expected no pulse", bus.data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          errors++;
          $display("FAIL data_out: got 0x%0h expected 0x%0h", bus.data_out, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_q.push_back(d);
    bus.fifo_words = occ();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    stream = 1'b0;
    bus.enable = 1'b1;
    bus.clr_stats = 1'b0;
    bus.fifo_words = 4'd0;
    bus.fifo_data = 8'h00;
    repeat (2) step();
    rst_n = 1'b1;
    dv_cnt = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    bit hit400;
    bit found;

    // Reset and idle
    rst_n = 1'b0;
    bus.enable = 1'b1;
    bus.clr_stats = 1'b0;
    bus.fifo_words = 4'd0;
    bus.fifo_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.rd_en, bus.data_valid, bus.data_out, bus.words_read, bus.err_count, bus.mismatch}, 64'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {bus.rd_en, bus.data_valid, bus.data_out, bus.words_read, bus.err_count, bus.mismatch}, 64'd0);
    end

    // Hysteresis drain: 5 words in, 3 read, stops at 2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step();
      push(8'hAA);
    end
    step();
    step();
    @(negedge clk);
    chk("below_high_mark_rd_en", bus.rd_en, 64'd0);
    step();
    push(8'hAA);
    @(negedge clk);
    chk("rd_en_before_transition", bus.rd_en, 64'd0);
    @(negedge clk);
    chk("rd_en_after_transition", bus.rd_en, 64'd1);
    repeat (8) @(negedge clk);
    chk("drain_words_read", bus.words_read, 64'd3);
    chk("drain_rd_en_low_mark", bus.rd_en, 64'd0);
    chk("drain_valid_pulses", dv_cnt, 64'd3);
    chk("drain_err_count", bus.err_count, 64'd0);
    chk("drain_mismatch", bus.mismatch, 64'd0);

    // Error detection and clear
    do_reset();
    step(); push(8'hAA);
    step(); push(8'h55);
    step(); push(8'hAA);
    step(); push(8'hAA);
    step(); push(8'hAA);
    repeat (10) @(negedge clk);
    chk("err_count_one", bus.err_count, 64'd1);
    chk("mismatch_sticky", bus.mismatch, 64'd1);
    chk("err_words_read", bus.words_read, 64'd3);
    chk("err_valid_pulses", dv_cnt, 64'd3);
    step();
    bus.clr_stats = 1'b1;
    step();
    bus.clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_stats", {bus.words_read, bus.err_count, bus.mismatch}, 64'd0);
    chk("clr_keeps_data_out", bus.data_out, 64'hAA);

    // enable gating holds READ
    do_reset();
    bus.enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      push(8'hAA);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rd_en !== 1'b0) seen = 1'b1;
    end
    chk("gated_rd_en", seen, 64'd0);
    chk("gated_words_read", bus.words_read, 64'd0);
    step();
    bus.enable = 1'b1;
    @(negedge clk);
    chk("resume_immediate", bus.rd_en, 64'd1);
    repeat (10) @(negedge clk);
    chk("resume_words_read", bus.words_read, 64'd4);
    chk("resume_valid_pulses", dv_cnt, 64'd4);

    // Reset in the cycle after a read strobe
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      push(8'hAA);
    end
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.rd_en === 1'b1) found = 1'b1;
    end
    chk("midrst_rd_en_seen", found, 64'd1);
    step();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_outputs", {bus.rd_en, bus.data_valid, bus.words_read, bus.err_count, bus.mismatch}, 64'd0);
    repeat (3) @(negedge clk);
    chk("midrst_no_valid", bus.data_valid, 64'd0);
    step();
    rst_n = 1'b1;
    dv_cnt = 0;
    @(negedge clk);
    chk("restart_reset_state", bus.rd_en, 64'd0);
    @(negedge clk);
    chk("restart_wait_state", bus.rd_en, 64'd0);
    @(negedge clk);
    chk("restart_read_state", bus.rd_en, 64'd1);
    repeat (10) @(negedge clk);
    chk("restart_words_read", bus.words_read, 64'd3);
    chk("restart_valid_pulses", dv_cnt, 64'd3);

    // Saturation and wrap with a continuously refilled bad-pattern FIFO
    do_reset();
    stream = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      push(8'h55);
    end
    hit400 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 70000 && !found; i++) begin
      @(negedge clk);
      if (bus.words_read == 16'd400 && !hit400) begin
        hit400 = 1'b1;
        chk("err_saturated_400", bus.err_count, 64'd255);
      end
      if (bus.words_read == 16'hFFFF) found = 1'b1;
    end
    chk("reached_65535", found, 64'd1);
    chk("err_saturated_end", bus.err_count, 64'd255);
    chk("wrap_rd_en", bus.rd_en, 64'd1);
    @(negedge clk);
    chk("words_read_wrap", bus.words_read, 64'd0);
    stream = 1'b0;
    repeat (20) @(negedge clk);
    chk("stream_drained", exp_q.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_fsm.md
# fifo_drain_fsm

Read-side controller for the 8-bit sync FIFO that the write-side FSM fills with the constant pattern 8'hAA. It watches the FIFO occupancy and drains the FIFO with hysteresis: idle until the FIFO reaches a high watermark, then read until it falls to a low watermark. Each word read is captured, presented downstream and checked against the expected pattern, with running read and error statistics. It sits between the FIFO read port and the downstream consumer/status logic.

## Interface
- DATA_W, 8, FIFO word width.
- CNT_W, 4, width of the FIFO occupancy count.
- HIGH_MARK, 5, occupancy at or above which draining starts.
- LOW_MARK, 2, occupancy at or below which draining stops; must satisfy LOW_MARK < HIGH_MARK.
- EXPECTED, 8'hAA, pattern every read word is checked against.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- enable  in  1  when 0, no new reads are issued; the state is held.
- clr_stats  in  1  synchronous clear of words_read, err_count and mismatch.
- fifo_words  in  CNT_W  current FIFO occupancy.
- fifo_data  in  DATA_W  FIFO read data; valid in the cycle after rd_en.
- rd_en  out  1  FIFO read strobe; one word is popped per cycle it is high.
- data_out  out  DATA_W  last word read (registered).
- data_valid  out  1  one-cycle pulse: data_out is new.
- words_read  out  16  count of rd_en cycles; wraps at 2^16.
- err_count  out  8  count of words not equal to EXPECTED; saturates at 255.
- mismatch  out  1  sticky flag; set on the first error.

## Operation
- States: RESET, WAIT, READ (2-bit encoding). Async reset forces RESET.
- RESET -> WAIT unconditionally on the next edge. rd_en = 0.
- WAIT -> READ when fifo_words >= HIGH_MARK. rd_en = 0.
- READ -> WAIT when fifo_words <= LOW_MARK; otherwise stay in READ.
- rd_en is combinational: (state == READ) && enable && (fifo_words > LOW_MARK). A read is therefore never issued at or below LOW_MARK, and never on an empty FIFO.
- enable = 0 in READ: rd_en = 0 and the state stays READ. enable does not gate the WAIT -> READ transition.
- Capture: rd_q <= rd_en. When rd_q = 1, on the next edge:
  - data_out <= fifo_data and data_valid <= 1; otherwise data_valid <= 0 and data_out holds its value.
  - In the same edge, if fifo_data != EXPECTED: err_count increments (saturating at 255) and mismatch <= 1.
- words_read increments on every edge where rd_en = 1, with modulo-2^16 wrap.
- clr_stats = 1: words_read, err_count and mismatch go to 0 on the next edge. Clear wins over any increment or set in the same cycle. data_out, data_valid and the FSM are unaffected.
- Occupancy increases from concurrent writes during READ keep the block reading until the low mark is reached.

## Timing
- Reset values: state RESET, rd_en 0, rd_q 0, data_out 0, data_valid 0, words_read 0, err_count 0, mismatch 0.
- First possible rd_en: 2 cycles after rst_n deasserts (RESET -> WAIT -> READ), given fifo_words >= HIGH_MARK.
- Latency: rd_en high in cycle N -> fifo_data sampled at the end of N+1 -> data_valid and data_out visible in N+2. There is one data_valid pulse per rd_en cycle, back-to-back with no bubbles.
- words_read is visible in cycle N+1; err_count and mismatch are visible in N+2.
- Reset mid-read: all outputs clear immediately (async). An in-flight rd_q is discarded and produces no data_valid after reset.
- A state transition takes effect on the edge after the fifo_words condition is seen. rd_en drops in the same cycle fifo_words reaches LOW_MARK.

## Test plan
- Reset/idle: hold rst_n = 0, then release with fifo_words = 0 -> rd_en stays 0 and every output is 0 for 20 cycles.
- Hysteresis drain: fifo_words rises 0..5 with data 8'hAA; model the pop -> rd_en asserts in the cycle after the WAIT -> READ edge. Exactly 3 words are read, and rd_en drops when fifo_words = 2. words_read = 3, 3 data_valid pulses with data_out = 8'hAA, err_count = 0.
- Error detection: the FIFO returns 8'hAA, 8'h55, 8'hAA -> err_count = 1 and mismatch = 1 two cycles after the bad read. mismatch stays 1 afterwards. clr_stats -> all three statistics return to 0.
- Saturation/wrap: 300 bad words -> err_count stays at 255. Preload the scenario to 65535 reads, then do one more read -> words_read = 0.
- enable gating: enable = 0 in READ with fifo_words = 6 -> rd_en = 0 and the state holds. enable = 1 -> reading resumes until fifo_words = 2.
- Reset mid-operation: assert rst_n during a burst, in the cycle after rd_en -> no data_valid pulse, counters read 0, and the FSM restarts from RESET.
